// File: rtl/mux_2x1_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// State encodings and mux-select values live here so every file decodes them identically.
package mux_2x1_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_A = 2'b01,
    ST_GNT_B = 2'b10
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // A hold limit of 1 still needs a 1-bit counter so the compare stays legal.
  function automatic int hold_cnt_width(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

endpackage

// File: rtl/mux_2x1_arbiter_mux.sv
// One-bit 2:1 mux slice; the arbiter replicates it once per data bit.
// Select follows the shared encoding: SEL_A routes a, SEL_B routes b.
module mux_2x1
  import mux_2x1_arbiter_pkg::*;
(
  input  logic sel,
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = (sel == SEL_B) ? b : a;

endmodule

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux datapath between requesters A and B.
// Define MUX_ARB_FIXED_PRIO_EN to make A win every tie (hold limit still protects B).
module mux_2x1_arbiter
  import mux_2x1_arbiter_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             last_a,
  input  logic [WIDTH-1:0] dat_a,
  input  logic             req_b,
  input  logic             last_b,
  input  logic [WIDTH-1:0] dat_b,
  input  logic             y_ready,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  localparam int               CNT_W     = hold_cnt_width(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             sel_q, sel_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
  logic             last_winner_q, last_winner_d;
`endif

  logic own_req;
  logic own_last;
  logic other_req;
  logic xfer;
  logic last_hit;
  logic hold_hit;
  logic release_evt;
  logic grant_a;
  logic grant_b;

  assign gnt_a   = (state_q == ST_GNT_A);
  assign gnt_b   = (state_q == ST_GNT_B);
  assign sel     = sel_q;
  assign y_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign xfer    = y_valid & y_ready;

  // View the current grantee as "own" and the waiting side as "other".
  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    own_req   = 1'b0;
    own_last  = 1'b0;
    other_req = 1'b0;
    case (state_q)
      ST_GNT_A: begin
        own_req   = req_a;
        own_last  = last_a;
        other_req = req_b;
      end
      ST_GNT_B: begin
        own_req   = req_b;
        own_last  = last_b;
        other_req = req_a;
      end
      default: ;
    endcase
  end

  assign last_hit    = xfer & own_last;
  assign hold_hit    = xfer & other_req & (hold_cnt_q == HOLD_LAST);
  assign release_evt = (state_q != ST_IDLE) & (last_hit | hold_hit | ~own_req);

  // Who gets the datapath at the next edge, if anyone is (re)granted at all.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_a && req_b) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
          grant_a = 1'b1;
`else
          grant_a = (last_winner_q == SEL_B);
          grant_b = (last_winner_q == SEL_A);
`endif
        end else begin
          grant_a = req_a;
          grant_b = req_b;
        end
      end
      ST_GNT_A: begin
        if (release_evt) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
          // A keeps a tie unless the hold limit is what ended its turn.
          if (req_b && (hold_hit || !req_a)) grant_b = 1'b1;
          else                                grant_a = req_a;
`else
          if (req_b) grant_b = 1'b1;
          else       grant_a = req_a;
`endif
        end
      end
      ST_GNT_B: begin
        if (release_evt) begin
          if (req_a) grant_a = 1'b1;
          else       grant_b = req_b;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    sel_d      = sel_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
    last_winner_d = last_winner_q;
`endif
    if (grant_a) begin
      state_d    = ST_GNT_A;
      hold_cnt_d = '0;
      sel_d      = SEL_A;
`ifndef MUX_ARB_FIXED_PRIO_EN
      last_winner_d = SEL_A;
`endif
    end else if (grant_b) begin
      state_d    = ST_GNT_B;
      hold_cnt_d = '0;
      sel_d      = SEL_B;
`ifndef MUX_ARB_FIXED_PRIO_EN
      last_winner_d = SEL_B;
`endif
    end else if (release_evt) begin
      state_d    = ST_IDLE;
      hold_cnt_d = '0;
    end else if (xfer && (hold_cnt_q != HOLD_LAST)) begin
      // Saturating: without contention the grantee may stream indefinitely.
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      sel_q      <= SEL_A;
`ifndef MUX_ARB_FIXED_PRIO_EN
      last_winner_q <= SEL_B;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      sel_q      <= sel_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
      last_winner_q <= last_winner_d;
`endif
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_2x1 u_mux (
      .sel (sel_q),
      .a   (dat_a[i]),
      .b   (dat_b[i]),
      .y   (y[i])
    );
  end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed bench for mux_2x1_arbiter: source queues emulate the requesters,
// a scoreboard queue holds the expected order of transferred beats.
module tb_mux_2x1_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
  localparam logic SA = 1'b0;
  localparam logic SB = 1'b1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, last_a, req_b, last_b, y_ready;
  logic [WIDTH-1:0] dat_a, dat_b, y;
  logic             gnt_a, gnt_b, sel, y_valid;

  typedef struct packed {
    logic             side;
    logic [WIDTH-1:0] dat;
    logic             last;
  } beat_t;

  beat_t src_a[$];
  beat_t src_b[$];
  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  mux_2x1_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .last_a  (last_a),
    .dat_a   (dat_a),
    .req_b   (req_b),
    .last_b  (last_b),
    .dat_b   (dat_b),
    .y_ready (y_ready),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue an n-beat packet on a source and its expected beats are pushed separately.
  task automatic add_pkt(input logic side, input logic [WIDTH-1:0] base, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.side = side;
      b.dat  = base + WIDTH'(i);
      b.last = (i == n - 1);
      if (side == SB) src_b.push_back(b);
      else            src_a.push_back(b);
    end
  endtask

  task automatic expect_beats(input logic side, input logic [WIDTH-1:0] base, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.side = side;
      b.dat  = base + WIDTH'(i);
      b.last = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic drive();
    req_a = (src_a.size() != 0);
    req_b = (src_b.size() != 0);
    if (req_a) begin dat_a = src_a[0].dat; last_a = src_a[0].last; end
    else       begin dat_a = WIDTH'($urandom); last_a = 1'($urandom); end
    if (req_b) begin dat_b = src_b[0].dat; last_b = src_b[0].last; end
    else       begin dat_b = WIDTH'($urandom); last_b = 1'($urandom); end
  endtask

  // Sample on the falling edge, score any transfer, then advance one clock.
  task automatic step();
    beat_t e;
    beat_t gone;
    @(negedge clk);
    if (y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", 32'(y), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("xfer_sel", 32'(sel), 32'(e.side));
        check("xfer_y", 32'(y), 32'(e.dat));
      end
      if (gnt_a && src_a.size() != 0) gone = src_a.pop_front();
      else if (gnt_b && src_b.size() != 0) gone = src_b.pop_front();
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt_a"}, 32'(gnt_a), 32'd0);
    check({tag, "_gnt_b"}, 32'(gnt_b), 32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    y_ready = 1'b1;

    // Reset with both requesters pending: nothing granted, A routed.
    add_pkt(SA, 8'h11, 1);
    add_pkt(SB, 8'h22, 1);
    drive();
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt_a", 32'(gnt_a), 32'd0);
      check("rst_gnt_b", 32'(gnt_b), 32'd0);
      check("rst_y_valid", 32'(y_valid), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_y", 32'(y), 32'h11);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    expect_beats(SA, 8'h11, 1);
    expect_beats(SB, 8'h22, 1);
    step();
    check("t1_first_gnt_a", 32'(gnt_a), 32'd1);
    check("t1_first_gnt_b", 32'(gnt_b), 32'd0);
    step();
    check("t1_then_gnt_b", 32'(gnt_b), 32'd1);
    step();
    step();
    check_idle("t1_idle");

    // B alone, three-beat packet.
    add_pkt(SB, 8'h30, 3);
    expect_beats(SB, 8'h30, 3);
    drive();
    step();
    check("t2_gnt_b", 32'(gnt_b), 32'd1);
    check("t2_sel", 32'(sel), 32'd1);
    check("t2_y", 32'(y), 32'h30);
    repeat (3) step();
    step();
    check_idle("t2_idle");
    check("t2_idle_sel_held", 32'(sel), 32'd1);

    // Both requesting single-beat packets: strict alternation, A first.
    for (int i = 0; i < 3; i++) begin
      add_pkt(SA, 8'hA0 + 8'(i), 1);
      add_pkt(SB, 8'hB0 + 8'(i), 1);
      expect_beats(SA, 8'hA0 + 8'(i), 1);
      expect_beats(SB, 8'hB0 + 8'(i), 1);
    end
    drive();
    step();
    for (int i = 0; i < 6; i++) begin
      check("t3_alt_gnt_a", 32'(gnt_a), 32'(i % 2 == 0));
      check("t3_alt_gnt_b", 32'(gnt_b), 32'(i % 2 == 1));
      step();
    end
    step();
    check_idle("t3_idle");

    // Long A packet under contention: hold limit forces a switch after 4 beats.
    add_pkt(SA, 8'h40, 10);
    add_pkt(SB, 8'hC0, 2);
    expect_beats(SA, 8'h40, 4);
    expect_beats(SB, 8'hC0, 2);
    expect_beats(SA, 8'h44, 6);
    drive();
    step();
    check("t4_gnt_a", 32'(gnt_a), 32'd1);
    repeat (4) step();
    check("t4_forced_gnt_b", 32'(gnt_b), 32'd1);
    repeat (2) step();
    check("t4_resume_gnt_a", 32'(gnt_a), 32'd1);
    repeat (6) step();
    step();
    check_idle("t4_idle");

    // Sink stalls mid-packet: state and data frozen, hold count untouched.
    add_pkt(SA, 8'h50, 6);
    drive();
    step();
    check("t5_gnt_a", 32'(gnt_a), 32'd1);
    add_pkt(SB, 8'h6A, 1);
    expect_beats(SA, 8'h50, 4);
    expect_beats(SB, 8'h6A, 1);
    expect_beats(SA, 8'h54, 2);
    drive();
    step();
    y_ready = 1'b0;
    repeat (5) begin
      step();
      check("t5_stall_gnt_a", 32'(gnt_a), 32'd1);
      check("t5_stall_gnt_b", 32'(gnt_b), 32'd0);
      check("t5_stall_sel", 32'(sel), 32'd0);
      check("t5_stall_y", 32'(y), 32'h51);
      check("t5_stall_valid", 32'(y_valid), 32'd1);
    end
    y_ready = 1'b1;
    repeat (3) step();
    check("t5_limit_gnt_b", 32'(gnt_b), 32'd1);
    step();
    check("t5_back_gnt_a", 32'(gnt_a), 32'd1);
    repeat (2) step();
    step();
    check_idle("t5_idle");

    // Reset lands during beat 2 of a B packet.
    add_pkt(SB, 8'h70, 4);
    expect_beats(SB, 8'h70, 1);
    drive();
    step();
    check("t6_gnt_b", 32'(gnt_b), 32'd1);
    step();
    rst     = 1'b1;
    y_ready = 1'b0;
    step();
    check("t6_rst_gnt_b", 32'(gnt_b), 32'd0);
    check("t6_rst_gnt_a", 32'(gnt_a), 32'd0);
    check("t6_rst_sel", 32'(sel), 32'd0);
    check("t6_rst_valid", 32'(y_valid), 32'd0);
    rst     = 1'b0;
    y_ready = 1'b1;
    add_pkt(SA, 8'h80, 1);
    expect_beats(SA, 8'h80, 1);
    expect_beats(SB, 8'h71, 3);
    drive();
    step();
    check("t6_post_gnt_a", 32'(gnt_a), 32'd1);
    repeat (4) step();
    step();
    check_idle("t6_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
